// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry output register and valid/ready handoff.
// Frame and handshake errors are reported as registered one-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rx_m, rx_s;
    logic          done, ferr;

    // Idle-high reset values keep a spurious start bit from appearing at reset release.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Re-check mid start bit so short low glitches are ignored.
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not be mistaken for a new start bit.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= ferr;
            o_overrun   <= 1'b0;
            if (done) begin
                // A same-cycle consume frees the slot for the new byte.
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-low.
REQ-004 i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-005 i_ready  input  1  consumer accepts o_data when high with o_valid.
REQ-006 o_data  output  8  received byte, LSB first on line.
REQ-007 o_valid  output  1  o_data holds an unconsumed byte.
REQ-008 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 o_overrun  output  1  one-cycle pulse: byte completed while previous unconsumed.
REQ-010 o_busy  output  1  high in every state except IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses synchronized rx_s only.
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; bit-period counter width ceil(log2(CLKS_PER_BIT)); 3-bit bit index.
REQ-014 IDLE: rx_s==0 -> START, counter cleared.
REQ-015 START: at counter==CLKS_PER_BIT/2-1 (integer divide) sample rx_s; 1 -> IDLE (glitch, no flag); 0 -> DATA, counter and bit index cleared.
REQ-016 DATA: at counter==CLKS_PER_BIT-1 shift rx_s into shift register MSB end (shift right) and clear counter; after index 7 sampled -> STOP, else index+1.
REQ-017 STOP: at counter==CLKS_PER_BIT-1 sample rx_s; 1 -> byte complete, IDLE; 0 -> o_frame_err pulse, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s==1, then IDLE (break/stuck-low line never restarts reception).
REQ-019 Byte complete with o_valid==0: o_data<=shift register, o_valid<=1 on the next edge (o_valid rises 1 cycle after stop-bit sample).
REQ-020 o_valid SHALL stay high and o_data stable until a cycle with o_valid&&i_ready; o_valid clears on the following edge.
REQ-021 Byte complete while o_valid==1 and i_ready==0: new byte dropped, o_data unchanged, o_overrun pulses 1 cycle.
REQ-022 Byte complete while o_valid==1 and i_ready==1 (same cycle): old byte consumed, new byte loaded, o_valid stays 1, no o_overrun.
REQ-023 o_frame_err and o_overrun SHALL be registered, high exactly one cycle per event, independent of the o_valid handshake.
REQ-024 i_ready while o_valid==0 SHALL have no effect.
REQ-025 Receiver timing SHALL never depend on i_ready; reception continues regardless of consumer stall.

Reset
REQ-026 While i_rst==0: state IDLE, counters 0, shift register 0, o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, sync flops=1.
REQ-027 Reset asserted mid-frame SHALL abort reception immediately; after release the block waits in IDLE for the next falling rx_s edge, no flags raised.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 8'hA5 with i_ready=1 -> o_valid high 1 cycle, o_data=8'hA5, first rise 1 cycle after stop sample; no flags.
REQ-029 Send 8'h3C then 8'hC3 back-to-back, i_ready=0 -> o_data stays 8'h3C, o_valid held, o_overrun one pulse at second stop sample; i_ready=1 then yields 8'h3C, o_valid clears.
REQ-030 Low pulse of 6 clocks on i_rx -> return to IDLE from START, o_valid=0, no flags.
REQ-031 Send 8'h55 with stop bit 0, line held low 40 clocks -> o_frame_err one pulse, o_valid=0, o_busy high until line high, then a following 8'h12 frame received correctly.
REQ-032 Assert i_rst during bit 4 of 8'hFF -> all outputs at reset values; subsequent 8'h81 received correctly.
REQ-033 o_valid=1, i_ready=1 in the exact cycle second byte completes -> o_valid stays 1, o_data=second byte, o_overrun=0.
